// File: rtl/tetron_collide.sv
// tetron_collide: checks the four blocks of a falling piece against the playfield.
//
// A check is started by req in IDLE. Each of the four blocks is classified in turn
// (one per ISSUE cycle) as a wall hit, a floor hit, above the board, or an in-board
// cell whose playfield row is read. Read data returns one cycle later and is
// evaluated alongside the next block (block 3's read is evaluated in DRAIN).
//
// Ports:
//   clk                      clock, rising edge
//   rst                      synchronous active-high reset
//   req                      start a check (sampled only in IDLE)
//   origin_row / origin_col  piece origin (row 0 is the top row)
//   blkN_voffset/hoffset     two's-complement block offsets, N = 1..4
//   rd_en / rd_row           playfield read strobe and row address
//   rd_data                  row occupancy, valid the cycle after rd_en
//   busy                     check in progress
//   done                     one-cycle pulse, result valid
//   collision / hit_mask     result; held until the next accepted req
//
// Configuration:
//   TETRON_COLLIDE_EARLY_EXIT_EN  when defined, the first detected hit ends the check.

module tetron_collide (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [4:0] origin_row,
  input  logic [3:0] origin_col,
  input  logic [4:0] blk1_voffset,
  input  logic [4:0] blk1_hoffset,
  input  logic [4:0] blk2_voffset,
  input  logic [4:0] blk2_hoffset,
  input  logic [4:0] blk3_voffset,
  input  logic [4:0] blk3_hoffset,
  input  logic [4:0] blk4_voffset,
  input  logic [4:0] blk4_hoffset,
  output logic       rd_en,
  output logic [4:0] rd_row,
  input  logic [9:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       collision,
  output logic [3:0] hit_mask
);

`ifdef TETRON_COLLIDE_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [4:0]  org_row_q;
  logic [3:0]  org_col_q;
  logic [4:0]  voff_q [4];
  logic [4:0]  hoff_q [4];
  logic [3:0]  mask_q, mask_d;
  logic        coll_q, coll_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  // Outstanding read: which block it belongs to and which column to test.
  logic        pend_q, pend_d;
  logic [1:0]  pend_idx_q, pend_idx_d;
  logic [3:0]  pend_col_q, pend_col_d;

  logic              accept;
  logic signed [5:0] row_s, col_s;
  logic              cls_wall, cls_floor, cls_read, cur_hit;
  logic [15:0]       rd_ext;
  logic              rd_hit;
  logic [3:0]        rd_hit_vec, cur_hit_vec;

  assign accept = (state_q == StIdle) && req;

  // Absolute position of the current block, 6-bit signed.
  always_comb begin
    row_s = $signed({1'b0, org_row_q}) + $signed({voff_q[idx_q][4], voff_q[idx_q]});
    col_s = $signed({2'b00, org_col_q}) + $signed({hoff_q[idx_q][4], hoff_q[idx_q]});
  end

  assign cls_wall  = (col_s < 6'sd0) || (col_s > 6'sd9);
  assign cls_floor = !cls_wall && (row_s > 6'sd19);
  assign cls_read  = !cls_wall && !cls_floor && (row_s >= 6'sd0);
  assign cur_hit   = cls_wall || cls_floor;

  assign rd_ext      = {6'd0, rd_data};
  assign rd_hit      = pend_q && rd_ext[pend_col_q];
  assign rd_hit_vec  = rd_hit ? (4'b0001 << pend_idx_q) : 4'b0000;
  assign cur_hit_vec = cur_hit ? (4'b0001 << idx_q) : 4'b0000;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    mask_d     = mask_q;
    coll_d     = coll_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pend_d     = 1'b0;
    pend_idx_d = pend_idx_q;
    pend_col_d = pend_col_q;
    rd_en      = 1'b0;
    rd_row     = 5'd0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StIssue;
          idx_d   = 2'd0;
          mask_d  = 4'b0000;
          coll_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StIssue: begin
        // With early exit, a read hit landing this cycle stops any further reads.
        if (cls_read && !(EarlyExit && rd_hit)) begin
          rd_en      = 1'b1;
          rd_row     = row_s[4:0];
          pend_d     = 1'b1;
          pend_idx_d = idx_q;
          pend_col_d = col_s[3:0];
        end
        mask_d = mask_q | cur_hit_vec | rd_hit_vec;
        if (EarlyExit && (cur_hit || rd_hit)) begin
          state_d = StDone;
          idx_d   = 2'd0;
          done_d  = 1'b1;
          coll_d  = 1'b1;
          busy_d  = 1'b0;
          pend_d  = 1'b0;
        end else if (idx_q == 2'd3) begin
          state_d = StDrain;
          idx_d   = 2'd0;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StDrain: begin
        mask_d  = mask_q | rd_hit_vec;
        state_d = StDone;
        done_d  = 1'b1;
        coll_d  = |mask_d;
        busy_d  = 1'b0;
      end
      StDone: begin
        state_d = StIdle;
        idx_d   = 2'd0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 2'd0;
      mask_q     <= 4'b0000;
      coll_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_idx_q <= 2'd0;
      pend_col_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mask_q     <= mask_d;
      coll_q     <= coll_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      pend_idx_q <= pend_idx_d;
      pend_col_q <= pend_col_d;
    end
  end

  // Operand capture needs no reset: only used after an accepted req.
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      org_row_q <= origin_row;
      org_col_q <= origin_col;
      voff_q[0] <= blk1_voffset;
      hoff_q[0] <= blk1_hoffset;
      voff_q[1] <= blk2_voffset;
      hoff_q[1] <= blk2_hoffset;
      voff_q[2] <= blk3_voffset;
      hoff_q[2] <= blk3_hoffset;
      voff_q[3] <= blk4_voffset;
      hoff_q[3] <= blk4_hoffset;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign collision = coll_q;
  assign hit_mask  = mask_q;

endmodule

// File: tb/tb_tetron_collide.sv
// Self-checking bench for tetron_collide: directed scenarios plus randomized checks
// against a block-by-block reference model of the collision rules.
module tb_tetron_collide;

`ifdef TETRON_COLLIDE_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic [4:0] origin_row = '0;
  logic [3:0] origin_col = '0;
  logic [4:0] blkv [4];
  logic [4:0] blkh [4];
  logic       rd_en;
  logic [4:0] rd_row;
  logic [9:0] rd_data = '0;
  logic       busy, done, collision;
  logic [3:0] hit_mask;

  int checks = 0;
  int failures = 0;

  logic [9:0] pf [20];
  int vo [4];
  int ho [4];

  always #5 clk = ~clk;

  tetron_collide dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .origin_row   (origin_row),
    .origin_col   (origin_col),
    .blk1_voffset (blkv[0]),
    .blk1_hoffset (blkh[0]),
    .blk2_voffset (blkv[1]),
    .blk2_hoffset (blkh[1]),
    .blk3_voffset (blkv[2]),
    .blk3_hoffset (blkh[2]),
    .blk4_voffset (blkv[3]),
    .blk4_hoffset (blkh[3]),
    .rd_en        (rd_en),
    .rd_row       (rd_row),
    .rd_data      (rd_data),
    .busy         (busy),
    .done         (done),
    .collision    (collision),
    .hit_mask     (hit_mask)
  );

  // Playfield memory: one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en && rd_row < 5'd20) rd_data <= pf[rd_row];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the blocks in order; a read's result is known one step later.
  task automatic model(input int orow, input int ocol, output logic [3:0] m,
                       output int done_e, output int nreads, output int rows [8]);
    bit prev_hit;
    bit hit_now;
    int r, c;
    m = 4'b0000;
    done_e = 5;
    nreads = 0;
    prev_hit = 1'b0;
    for (int t = 0; t < 4; t++) rows[t] = -1;
    for (int t = 0; t <= 4; t++) begin
      bit read_hit_now;
      read_hit_now = 1'b0;
      hit_now = 1'b0;
      if (t > 0 && prev_hit) begin
        m[t-1] = 1'b1;
        hit_now = 1'b1;
        read_hit_now = 1'b1;
      end
      if (t == 4) break;
      prev_hit = 1'b0;
      r = orow + vo[t];
      c = ocol + ho[t];
      if (c < 0 || c > 9 || r > 19) begin
        m[t] = 1'b1;
        hit_now = 1'b1;
      end else if (r >= 0 && !(EarlyExit && read_hit_now)) begin
        rows[nreads] = r;
        nreads++;
        prev_hit = pf[r][c];
      end
      if (EarlyExit && hit_now) begin
        done_e = t + 1;
        return;
      end
    end
  endtask

  task automatic drive_ops(input int orow, input int ocol);
    origin_row = 5'(orow);
    origin_col = 4'(ocol);
    for (int i = 0; i < 4; i++) begin
      blkv[i] = 5'(vo[i]);
      blkh[i] = 5'(ho[i]);
    end
  endtask

  task automatic run_check(input string tag, input int orow, input int ocol);
    logic [3:0] em;
    int ed, en;
    int er [8];
    int gr [8];
    int cyc, got_done, nr;
    model(orow, ocol, em, ed, en, er);
    @(negedge clk);
    drive_ops(orow, ocol);
    req = 1'b1;
    cyc = 0;
    got_done = -1;
    nr = 0;
    while (cyc < 20 && got_done < 0) begin
      @(negedge clk);
      cyc++;
      req = 1'b0;
      if (cyc == 1) check({tag, ".busy"}, 32'(busy), 32'd1);
      if (rd_en) begin
        if (nr < 8) gr[nr] = int'(rd_row);
        nr++;
      end
      if (done) got_done = cyc - 1;
    end
    check({tag, ".done_edge"}, 32'(got_done), 32'(ed));
    check({tag, ".hit_mask"}, 32'(hit_mask), 32'(em));
    check({tag, ".collision"}, 32'(collision), 32'(|em));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
    check({tag, ".nreads"}, 32'(nr), 32'(en));
    if (nr == en) begin
      for (int i = 0; i < en; i++) check({tag, ".row"}, 32'(gr[i]), 32'(er[i]));
    end
    @(negedge clk);
    check({tag, ".done_width"}, 32'(done), 32'd0);
    check({tag, ".hold_mask"}, 32'(hit_mask), 32'(em));
  endtask

  task automatic std_offsets();
    vo[0] = 0;  ho[0] = 0;
    vo[1] = -1; ho[1] = 0;
    vo[2] = 0;  ho[2] = -1;
    vo[3] = 1;  ho[3] = -1;
  endtask

  task automatic clear_pf();
    for (int r = 0; r < 20; r++) pf[r] = 10'd0;
  endtask

  initial begin
    int accept_edge, done_cnt, cyc;
    logic prev_busy;
    for (int i = 0; i < 4; i++) begin
      blkv[i] = '0;
      blkh[i] = '0;
    end
    clear_pf();
    std_offsets();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.collision", 32'(collision), 32'd0);
    check("reset.hit_mask", 32'(hit_mask), 32'd0);
    check("reset.rd_en", 32'(rd_en), 32'd0);

    run_check("empty", 5, 5);
    run_check("wall", 5, 0);
    run_check("floor", 19, 5);
    pf[6][4] = 1'b1;
    run_check("drain_hit", 5, 5);
    clear_pf();
    run_check("above", 0, 5);

    // Reset mid-check: block 1 reads a filled cell, reset lands at the end of idx=2.
    pf[0][5] = 1'b1;
    @(negedge clk);
    drive_ops(0, 5);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("midrst.no_read_blk2", 32'(rd_en), 32'd0);
    @(negedge clk);
    check("midrst.partial_mask", 32'(hit_mask), 32'b0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.hit_mask", 32'(hit_mask), 32'd0);
    check("midrst.rd_en", 32'(rd_en), 32'd0);
    clear_pf();

    // Reset wins over a simultaneous req.
    @(negedge clk);
    rst = 1'b1;
    req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    check("rst_prio.busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("rst_prio.not_queued", 32'(busy), 32'd0);

    // req held high: one completion before the second accept.
    drive_ops(5, 5);
    req = 1'b1;
    accept_edge = -1;
    done_cnt = 0;
    prev_busy = 1'b0;
    cyc = 0;
    while (cyc < 12 && accept_edge < 0) begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (busy && !prev_busy && cyc > 1) accept_edge = cyc - 1;
      prev_busy = busy;
    end
    req = 1'b0;
    check("held.second_accept_seen", 32'(accept_edge >= 0), 32'd1);
    check("held.accept_not_early", 32'(accept_edge >= 6), 32'd1);
    check("held.one_done", 32'(done_cnt), 32'd1);
    repeat (8) @(negedge clk);
    check("held.idle_after", 32'(busy), 32'd0);

    // Randomized checks.
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 20; r++) pf[r] = 10'($urandom & $urandom);
      for (int i = 0; i < 4; i++) begin
        vo[i] = int'($urandom_range(0, 6)) - 3;
        ho[i] = int'($urandom_range(0, 6)) - 3;
      end
      run_check("rand", int'($urandom_range(0, 19)), int'($urandom_range(0, 9)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
